seq_divider: RTL and testbench
==============================

# seq_divider

Sequential restoring divider: the inverse of the team's shift-add multiplier datapath. It takes an unsigned WIDTH-bit dividend and divisor and produces the quotient and remainder with one shift-subtract step per clock. The block holds its own control FSM and a start/busy/done handshake, so an upstream controller or testbench can drive it directly alongside the multiplier.

## Interface
Parameters:
- WIDTH, 32, operand width. Quotient and remainder are also WIDTH bits.

Ports:
- clk  input  1  rising-edge clock; the block has a single clock.
- reset  input  1  asynchronous, active-low reset. Asserted (0) clears all state immediately.
- start  input  1  request pulse, sampled only in IDLE.
- dividend  input  WIDTH  unsigned dividend, captured on an accepted start.
- divisor  input  WIDTH  unsigned divisor, captured on an accepted start.
- busy  output  1  high in RUN.
- done  output  1  single-cycle pulse; results are valid in that cycle.
- quotient  output  WIDTH  result quotient, held until the next accepted start.
- remainder  output  WIDTH  result remainder, held until the next accepted start.
- div_by_zero  output  1  divide-by-zero flag, qualified by done.

## Operation
- State machine: IDLE, RUN, DONE.
- Internal registers:
  - rem, WIDTH bits.
  - q, WIDTH bits (shift register).
  - d, WIDTH bits (captured divisor).
  - cnt, $clog2(WIDTH)+1 bits.
- IDLE with start=1 (accepted start):
  - rem<=0, q<=dividend, d<=divisor, cnt<=WIDTH.
  - Next state RUN.
- IDLE with start=0: stay in IDLE.
- RUN, each cycle:
  - Form s = {rem, q[WIDTH-1]}, WIDTH+1 bits.
  - Form t = s - {1'b0, d}, WIDTH+1 bits.
  - If t[WIDTH]==0: rem<=t[WIDTH-1:0] and q<={q[WIDTH-2:0],1}.
  - Else: rem<=s[WIDTH-1:0] and q<={q[WIDTH-2:0],0}.
  - cnt<=cnt-1.
  - When cnt==1, next state DONE.
- DONE:
  - done=1 for exactly one cycle.
  - quotient and remainder drive q and rem, which remain stable afterwards.
  - Next state IDLE.
- start in RUN or DONE is ignored. No queuing; operands are not re-captured.
- quotient and remainder are register outputs. They change only on the last RUN step and on a reset.
- Divisor 0 without the macro: the algorithm runs to completion and yields quotient = all ones, remainder = dividend. div_by_zero stays 0.
- Divisor greater than dividend: quotient 0, remainder = dividend.

## Timing
- Reset values: all state cleared; every output is 0:
  - state=IDLE
  - busy=0
  - done=0
  - quotient=0
  - remainder=0
  - div_by_zero=0
- Reset asserted mid-RUN aborts the operation. After release the block is in IDLE and accepts start on the first rising edge.
- Latency, with start accepted at edge k:
  - busy is high after edges k through k+WIDTH-1.
  - done is high during the cycle following edge k+WIDTH, i.e. WIDTH+1 cycles after start.
- Back-to-back throughput: a new start is accepted at the earliest in the cycle after done (IDLE), so one operation per WIDTH+2 cycles.
- busy and done are never high in the same cycle.

## Configuration
- SEQ_DIVIDER_ZERO_DETECT_EN:
  - Defined: an accepted start with divisor==0 skips RUN and goes IDLE→DONE.
    - done is high one cycle after the start edge.
    - div_by_zero=1 with done.
    - quotient = all ones, remainder = dividend (same values as the undetected path).
    - busy stays 0.
  - Not defined: no zero check. div_by_zero is tied to 0, and divisor 0 takes the full WIDTH+1 cycle latency.

## Test plan
- dividend=100, divisor=7, start at edge 0 → done high after edge 32; quotient=14, remainder=2, busy high for 32 cycles.
- dividend=0xFFFFFFFF, divisor=1 → quotient=0xFFFFFFFF, remainder=0. Then dividend=0xFFFFFFFF, divisor=0xFFFFFFFF → quotient=1, remainder=0.
- dividend=5, divisor=9 → quotient=0, remainder=5. A second start pulsed during RUN with dividend=50 is ignored; the result stays 0/5 and exactly one done pulse occurs.
- dividend=1234, divisor=0:
  - Macro defined → done one cycle after start, div_by_zero=1, quotient=0xFFFFFFFF, remainder=1234.
  - Macro undefined → done after 33 cycles, same values, div_by_zero=0.
- Start 1000/3, assert reset at RUN cycle 10 → all outputs 0 immediately. After release, start 1000/3 again → quotient=333, remainder=1.
- 200 random operand pairs (divisor≠0), back-to-back starts issued in IDLE → quotient and remainder match a reference model; one done per start.

Source files
------------

// File: rtl/seq_divider.sv
// Sequential restoring divider: one shift-subtract step per clock, start/busy/done handshake.
// Optional macro SEQ_DIVIDER_ZERO_DETECT_EN short-circuits divide-by-zero straight to DONE.
module seq_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   quotient_q, quotient_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH:0]     s_c;
    logic [WIDTH:0]     t_c;
`ifdef SEQ_DIVIDER_ZERO_DETECT_EN
    logic               dbz_q, dbz_d;
`endif

    // Next-state, datapath and result-register update.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        q_d         = q_q;
        d_d         = d_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
`ifdef SEQ_DIVIDER_ZERO_DETECT_EN
        dbz_d       = 1'b0;
`endif
        s_c = {rem_q, q_q[WIDTH-1]};
        t_c = s_c - {1'b0, d_q};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    d_d = divisor;
`ifdef SEQ_DIVIDER_ZERO_DETECT_EN
                    if (divisor == '0) begin
                        // Same result the full run would produce, without the wait.
                        q_d         = '1;
                        rem_d       = dividend;
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        rem_d   = '0;
                        q_d     = dividend;
                        cnt_d   = CNT_W'(WIDTH);
                        state_d = S_RUN;
                    end
`else
                    rem_d   = '0;
                    q_d     = dividend;
                    cnt_d   = CNT_W'(WIDTH);
                    state_d = S_RUN;
`endif
                end
            end
            S_RUN: begin
                if (!t_c[WIDTH]) begin
                    rem_d = t_c[WIDTH-1:0];
                    q_d   = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = s_c[WIDTH-1:0];
                    q_d   = {q_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    quotient_d  = q_d;
                    remainder_d = rem_d;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            q_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            q_q         <= q_d;
            d_q         <= d_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

`ifdef SEQ_DIVIDER_ZERO_DETECT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dbz_q <= 1'b0;
        end else begin
            dbz_q <= dbz_d;
        end
    end

    assign div_by_zero = dbz_q;
`else
    assign div_by_zero = 1'b0;
`endif

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed scenarios plus randomized back-to-back divisions
// checked against plain integer division (define SEQ_DIVIDER_ZERO_DETECT_EN to match the RTL build).
module tb_seq_divider;

    localparam int unsigned W = 32;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int vectors = 0;
    int errors  = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: unsigned division; divisor 0 yields all-ones quotient and the dividend as remainder.
    function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == '0) return {{W{1'b1}}, a};
        return {a / b, a % b};
    endfunction

    // Launch one operation in an IDLE cycle and observe it until done; returns in the following IDLE cycle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] qo, output logic [W-1:0] ro, output logic dzo,
                          output int lat, output int busy_cyc, output int both_hi,
                          output int hold_bad, output logic done_after);
        logic [W-1:0] q0, r0;
        @(negedge clk);
        q0 = quotient;
        r0 = remainder;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        qo = 'x; ro = 'x; dzo = 1'bx;
        lat = -1; busy_cyc = 0; both_hi = 0; hold_bad = 0;
        for (int i = 0; i < int'(W) + 8; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            if (busy && done) both_hi++;
            if (busy) busy_cyc++;
            if (done) begin
                lat = i; qo = quotient; ro = remainder; dzo = div_by_zero;
                break;
            end
            if (quotient !== q0 || remainder !== r0) hold_bad++;
        end
        @(posedge clk);
        #1 done_after = done;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        #12;
        vectors++; if ({busy, done, div_by_zero} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {busy, done, div_by_zero}); end
        vectors++; if (quotient !== '0) begin errors++; $display("FAIL reset_quotient: got %h expected 0", quotient); end
        vectors++; if (remainder !== '0) begin errors++; $display("FAIL reset_remainder: got %h expected 0", remainder); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_basic();
        logic [W-1:0] qo, ro; logic dzo, da; int lat, bc, bh, hb;
        run_op(32'd100, 32'd7, qo, ro, dzo, lat, bc, bh, hb, da);
        vectors++; if (qo !== 32'd14) begin errors++; $display("FAIL basic_quotient: got %0d expected 14", qo); end
        vectors++; if (ro !== 32'd2) begin errors++; $display("FAIL basic_remainder: got %0d expected 2", ro); end
        vectors++; if (lat !== int'(W)) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", lat, W); end
        vectors++; if (bc !== int'(W)) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected %0d", bc, W); end
        vectors++; if (bh !== 0) begin errors++; $display("FAIL basic_busy_and_done: got %0d expected 0", bh); end
        vectors++; if (hb !== 0) begin errors++; $display("FAIL basic_result_hold: got %0d early changes expected 0", hb); end
        vectors++; if (da !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b after done expected 0", da); end
        vectors++; if (dzo !== 1'b0) begin errors++; $display("FAIL basic_dbz: got %b expected 0", dzo); end
    endtask

    task automatic test_extremes();
        logic [W-1:0] qo, ro; logic dzo, da; int lat, bc, bh, hb;
        run_op('1, 32'd1, qo, ro, dzo, lat, bc, bh, hb, da);
        vectors++; if (qo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL max_div1_quotient: got %h expected ffffffff", qo); end
        vectors++; if (ro !== 32'd0) begin errors++; $display("FAIL max_div1_remainder: got %h expected 0", ro); end
        run_op('1, '1, qo, ro, dzo, lat, bc, bh, hb, da);
        vectors++; if (qo !== 32'd1) begin errors++; $display("FAIL max_divmax_quotient: got %h expected 1", qo); end
        vectors++; if (ro !== 32'd0) begin errors++; $display("FAIL max_divmax_remainder: got %h expected 0", ro); end
    endtask

    task automatic test_ignored_start();
        int dones = 0;
        @(negedge clk);
        dividend = 32'd5; divisor = 32'd9; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < int'(W) + 6; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            if (i == 5) begin start = 1'b1; dividend = 32'd50; divisor = 32'd3; end
            if (i == 6) start = 1'b0;
            if (i == int'(W)) start = 1'b1;
            if (i == int'(W) + 1) start = 1'b0;
            if (done) dones++;
        end
        vectors++; if (dones !== 1) begin errors++; $display("FAIL ignored_start_done_count: got %0d expected 1", dones); end
        vectors++; if (quotient !== 32'd0) begin errors++; $display("FAIL ignored_start_quotient: got %0d expected 0", quotient); end
        vectors++; if (remainder !== 32'd5) begin errors++; $display("FAIL ignored_start_remainder: got %0d expected 5", remainder); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL ignored_start_relaunch: busy %b expected 0", busy); end
    endtask

    task automatic test_div_zero();
        logic [W-1:0] qo, ro; logic dzo, da; int lat, bc, bh, hb;
        int exp_lat, exp_bc; logic exp_dz;
`ifdef SEQ_DIVIDER_ZERO_DETECT_EN
        exp_lat = 0; exp_bc = 0; exp_dz = 1'b1;
`else
        exp_lat = int'(W); exp_bc = int'(W); exp_dz = 1'b0;
`endif
        run_op(32'd1234, 32'd0, qo, ro, dzo, lat, bc, bh, hb, da);
        vectors++; if (qo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dbz_quotient: got %h expected ffffffff", qo); end
        vectors++; if (ro !== 32'd1234) begin errors++; $display("FAIL dbz_remainder: got %0d expected 1234", ro); end
        vectors++; if (lat !== exp_lat) begin errors++; $display("FAIL dbz_latency: got %0d expected %0d", lat, exp_lat); end
        vectors++; if (bc !== exp_bc) begin errors++; $display("FAIL dbz_busy_cycles: got %0d expected %0d", bc, exp_bc); end
        vectors++; if (dzo !== exp_dz) begin errors++; $display("FAIL dbz_flag: got %b expected %b", dzo, exp_dz); end
        vectors++; if (da !== 1'b0) begin errors++; $display("FAIL dbz_done_pulse: got %b after done expected 0", da); end
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] qo, ro; logic dzo, da; int lat, bc, bh, hb;
        @(negedge clk);
        dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        vectors++; if ({busy, done, div_by_zero} !== 3'b000) begin errors++; $display("FAIL midrun_reset_flags: got %b expected 000", {busy, done, div_by_zero}); end
        vectors++; if ({quotient, remainder} !== '0) begin errors++; $display("FAIL midrun_reset_results: got %h/%h expected 0/0", quotient, remainder); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        run_op(32'd1000, 32'd3, qo, ro, dzo, lat, bc, bh, hb, da);
        vectors++; if (qo !== 32'd333) begin errors++; $display("FAIL post_reset_quotient: got %0d expected 333", qo); end
        vectors++; if (ro !== 32'd1) begin errors++; $display("FAIL post_reset_remainder: got %0d expected 1", ro); end
        vectors++; if (lat !== int'(W)) begin errors++; $display("FAIL post_reset_latency: got %0d expected %0d", lat, W); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] qo, ro, a, b; logic [2*W-1:0] exp; logic dzo, da; int lat, bc, bh, hb;
        for (int n = 0; n < 200; n++) begin
            a = $urandom;
            case (n % 4)
                0: b = W'($urandom_range(1, 255));
                1: b = $urandom >> $urandom_range(0, 31);
                2: begin a = a >> $urandom_range(0, 31); b = $urandom; end
                default: b = $urandom;
            endcase
            if (b == '0) b = W'(1);
            exp = ref_div(a, b);
            run_op(a, b, qo, ro, dzo, lat, bc, bh, hb, da);
            vectors++; if (qo !== exp[2*W-1:W]) begin errors++; $display("FAIL rand_quotient[%0d]: %h/%h got %h expected %h", n, a, b, qo, exp[2*W-1:W]); end
            vectors++; if (ro !== exp[W-1:0]) begin errors++; $display("FAIL rand_remainder[%0d]: %h/%h got %h expected %h", n, a, b, ro, exp[W-1:0]); end
            vectors++; if (lat !== int'(W) || bh !== 0) begin errors++; $display("FAIL rand_timing[%0d]: latency %0d overlap %0d expected %0d/0", n, lat, bh, W); end
            vectors++; if (da !== 1'b0) begin errors++; $display("FAIL rand_done_pulse[%0d]: got %b after done expected 0", n, da); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_ignored_start();
        test_div_zero();
        test_reset_mid_run();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
